// File: rtl/hazard_fwd_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared types and constants for the EX forwarding / load scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Default architectural register file size and its index width.
    localparam int NUM_REGS_DEF = 32;
    localparam int REG_AW       = $clog2(NUM_REGS_DEF);

    // Bypass source per EX operand; 2'b11 is reserved and never produced.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } haz_state_e;

    // Width needed to hold 0..max_out inclusive.
    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_scoreboard_if
// Brief    : Pipeline-side bundle of the hazard/forwarding scoreboard.
//            master = pipeline control side, slave = scoreboard.
//            Perf counter signals exist only with HAZ_PERF_CNT_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_fwd_scoreboard_if #(
    parameter int NUM_SRC  = 2,
    parameter int NUM_REGS = 32,
    parameter int PERF_W   = 32
);
    localparam int REG_AW = $clog2(NUM_REGS);

    // ID stage
    logic                      id_advance;
    logic [NUM_SRC*REG_AW-1:0] id_rs;
    logic [NUM_SRC-1:0]        id_rs_used;
    logic [REG_AW-1:0]         id_rd;
    logic                      id_is_load;
    // EX / MEM / WB stages
    logic [NUM_SRC*REG_AW-1:0] ex_rs;
    logic [NUM_SRC-1:0]        ex_rs_used;
    logic [REG_AW-1:0]         mem_rd;
    logic                      mem_wr_en;
    logic [REG_AW-1:0]         wb_rd;
    logic                      wb_wr_en;
    // Load responses and control
    logic                      ld_rsp_valid;
    logic [REG_AW-1:0]         ld_rsp_rd;
    logic                      flush;
    // Results
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic                      stall_id;
    logic                      bubble_ex;
    logic [NUM_REGS-1:0]       busy_vec;
    logic                      sb_err;
`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0]         perf_stall_cnt;
    logic [PERF_W-1:0]         perf_fwd_cnt;
`endif

    modport master (
        output id_advance, id_rs, id_rs_used, id_rd, id_is_load,
        output ex_rs, ex_rs_used, mem_rd, mem_wr_en, wb_rd, wb_wr_en,
        output ld_rsp_valid, ld_rsp_rd, flush,
        input  fwd_sel, stall_id, bubble_ex, busy_vec, sb_err
`ifdef HAZ_PERF_CNT_EN
        , input perf_stall_cnt, perf_fwd_cnt
`endif
    );

    modport slave (
        input  id_advance, id_rs, id_rs_used, id_rd, id_is_load,
        input  ex_rs, ex_rs_used, mem_rd, mem_wr_en, wb_rd, wb_wr_en,
        input  ld_rsp_valid, ld_rsp_rd, flush,
        output fwd_sel, stall_id, bubble_ex, busy_vec, sb_err
`ifdef HAZ_PERF_CNT_EN
        , output perf_stall_cnt, perf_fwd_cnt
`endif
    );

endinterface
`default_nettype wire

// File: rtl/hazard_fwd_scoreboard_fwd_select.sv
`default_nettype none
// ============================================================================
// Module   : fwd_select
// Brief    : Bypass source choice for one EX operand. MEM beats WB, and
//            register 0 never forwards.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_select
    import hazard_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] i_rs,
    input  logic          i_used,
    input  logic [AW-1:0] i_mem_rd,
    input  logic          i_mem_wr_en,
    input  logic [AW-1:0] i_wb_rd,
    input  logic          i_wb_wr_en,
    output fwd_sel_e      o_sel
);
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_used && i_mem_wr_en && (i_mem_rd != '0) && (i_mem_rd == i_rs);
    assign w_wb_hit  = i_used && i_wb_wr_en  && (i_wb_rd  != '0) && (i_wb_rd  == i_rs);

    // Youngest producer (MEM) wins over the older one (WB).
    always_comb begin
        o_sel = FWD_RF;
        if (w_mem_hit) begin
            o_sel = FWD_MEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_scoreboard
// Brief    : EX operand bypass selection for NUM_SRC operands, per-register
//            load scoreboard, outstanding-load counter and the ID-stall /
//            EX-bubble control FSM with mispredict flush handling.
//            Optional: HAZ_PERF_CNT_EN adds stall / forward perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_SRC         = 2,
    parameter int NUM_REGS        = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int PERF_W          = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    hazard_fwd_scoreboard_if.slave   bus
);
    localparam int REG_AW = $clog2(NUM_REGS);
    localparam int CNT_W  = cnt_width(MAX_OUTSTANDING);

    logic [NUM_SRC*2-1:0] w_fwd_sel;
    logic [REG_AW-1:0]    w_id_rs [NUM_SRC];

    logic [NUM_REGS-1:0]  r_busy;
    logic [NUM_REGS-1:0]  w_busy_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 r_sb_err;
    logic                 w_err_evt;
    logic                 w_ld_issue;
    logic                 w_use_hazard;
    logic                 w_hazard;

    haz_state_e           r_state;
    haz_state_e           w_state_nxt;
    logic                 w_stall_id;
    logic                 w_bubble_ex;

    // ------------------------------------------------------------------
    // Per-operand bypass selection and ID source index extraction
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        fwd_sel_e w_sel;

        fwd_select #(
            .AW (REG_AW)
        ) u_fwd_select (
            .i_rs        (bus.ex_rs[gi*REG_AW +: REG_AW]),
            .i_used      (bus.ex_rs_used[gi]),
            .i_mem_rd    (bus.mem_rd),
            .i_mem_wr_en (bus.mem_wr_en),
            .i_wb_rd     (bus.wb_rd),
            .i_wb_wr_en  (bus.wb_wr_en),
            .o_sel       (w_sel)
        );

        assign w_fwd_sel[gi*2 +: 2] = w_sel;
        assign w_id_rs[gi]          = bus.id_rs[gi*REG_AW +: REG_AW];
    end

    // A load leaves ID for real only when the slot is not being squashed.
    assign w_ld_issue = bus.id_advance && bus.id_is_load && !bus.flush;

    // Scoreboard next value: clear on response, then set on issue so a new
    // load to the same register overrides the returning one. x0 never sets.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (bus.ld_rsp_valid && (bus.ld_rsp_rd == REG_AW'(r))) begin
                w_busy_nxt[r] = 1'b0;
            end
        end
        for (int r = 1; r < NUM_REGS; r++) begin
            if (w_ld_issue && (bus.id_rd == REG_AW'(r))) begin
                w_busy_nxt[r] = 1'b1;
            end
        end
    end

    // Outstanding-load count; a response with nothing in flight is an error
    // and must not underflow the count.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_err_evt = bus.ld_rsp_valid && (r_cnt == '0);
        if (w_ld_issue && !bus.ld_rsp_valid) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (!w_ld_issue && bus.ld_rsp_valid && (r_cnt != '0)) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

    // Scoreboard, count and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= '0;
            r_cnt    <= '0;
            r_sb_err <= 1'b0;
        end else begin
            r_busy   <= w_busy_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sb_err <= r_sb_err | w_err_evt;
        end
    end

    // Any used ID source waiting on an in-flight load.
    always_comb begin
        w_use_hazard = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (bus.id_rs_used[i] && r_busy[r] && (w_id_rs[i] == REG_AW'(r))) begin
                    w_use_hazard = 1'b1;
                end
            end
        end
    end

    assign w_hazard = w_use_hazard ||
                      (bus.id_is_load && (r_cnt == CNT_W'(MAX_OUTSTANDING)));

    // Control FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Control FSM next state and stall / bubble outputs; flush overrides all.
    always_comb begin
        w_state_nxt = r_state;
        w_stall_id  = 1'b0;
        w_bubble_ex = 1'b0;

        if (bus.flush) begin
            w_state_nxt = FLUSH;
        end else begin
            case (r_state)
                RUN:     w_state_nxt = w_hazard ? STALL : RUN;
                STALL:   w_state_nxt = w_hazard ? STALL : RUN;
                FLUSH:   w_state_nxt = RUN;
                default: w_state_nxt = RUN;
            endcase
        end

        w_stall_id  = w_hazard && !bus.flush && (r_state != FLUSH);
        w_bubble_ex = w_stall_id || bus.flush || (r_state == FLUSH);
    end

    assign bus.fwd_sel   = w_fwd_sel;
    assign bus.stall_id  = w_stall_id;
    assign bus.bubble_ex = w_bubble_ex;
    assign bus.busy_vec  = r_busy;
    assign bus.sb_err    = r_sb_err;

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] r_perf_stall_cnt;
    logic [PERF_W-1:0] r_perf_fwd_cnt;
    logic [PERF_W-1:0] w_fwd_active;

    // Number of operands being bypassed this cycle.
    always_comb begin
        w_fwd_active = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_fwd_sel[i*2 +: 2] != 2'b00) begin
                w_fwd_active = w_fwd_active + PERF_W'(1);
            end
        end
    end

    // Free-running, wrapping perf counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall_cnt <= '0;
            r_perf_fwd_cnt   <= '0;
        end else begin
            if (w_stall_id) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + PERF_W'(1);
            end
            r_perf_fwd_cnt <= r_perf_fwd_cnt + w_fwd_active;
        end
    end

    assign bus.perf_stall_cnt = r_perf_stall_cnt;
    assign bus.perf_fwd_cnt   = r_perf_fwd_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_fwd_scoreboard
// Brief    : Scoreboard bench for hazard_fwd_scoreboard (MAX_OUTSTANDING=2).
//            Driver pushes reference-model expectations; a negedge monitor
//            pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_scoreboard;
    localparam int NS   = 2;
    localparam int NR   = 32;
    localparam int MAXO = 2;
    localparam int AW   = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_fwd_scoreboard_if #(.NUM_SRC(NS), .NUM_REGS(NR), .PERF_W(32)) bus ();

    hazard_fwd_scoreboard #(
        .NUM_SRC         (NS),
        .NUM_REGS        (NR),
        .MAX_OUTSTANDING (MAXO),
        .PERF_W          (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2*NS-1:0] fwd;
        logic            stall;
        logic            bubble;
        logic [NR-1:0]   busy;
        logic            err;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state: which registers await a load, how many loads
    // are in flight, sticky error, and whether the previous cycle flushed.
    bit   m_busy [NR];
    int   m_cnt;
    bit   m_err;
    bit   m_prev_flush;
    logic [AW-1:0] pending[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
        m_cnt        = 0;
        m_err        = 1'b0;
        m_prev_flush = 1'b0;
        pending.delete();
    endtask

    function automatic logic [1:0] ref_fwd(input int i);
        logic [AW-1:0] rs;
        rs = bus.ex_rs[i*AW +: AW];
        if (!bus.ex_rs_used[i] || rs == 0)          return 2'b00;
        if (bus.mem_wr_en && bus.mem_rd == rs)      return 2'b01;
        if (bus.wb_wr_en  && bus.wb_rd  == rs)      return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit ref_hazard();
        bit h;
        logic [AW-1:0] rs;
        h = bus.id_is_load && (m_cnt == MAXO);
        for (int i = 0; i < NS; i++) begin
            rs = bus.id_rs[i*AW +: AW];
            if (bus.id_rs_used[i] && rs != 0 && m_busy[rs]) h = 1'b1;
        end
        return h;
    endfunction

    // Compute this cycle's expected outputs, queue them, then advance model.
    task automatic expect_and_update();
        exp_t e;
        bit   haz, issue;
        if (!rst_n) model_reset();
        for (int i = 0; i < NS; i++) e.fwd[2*i +: 2] = ref_fwd(i);
        haz      = ref_hazard();
        e.stall  = haz && !bus.flush && !m_prev_flush;
        e.bubble = e.stall || bus.flush || m_prev_flush;
        for (int r = 0; r < NR; r++) e.busy[r] = m_busy[r];
        e.err    = m_err;
        q.push_back(e);
        if (rst_n) begin
            issue = bus.id_advance && bus.id_is_load && !bus.flush;
            if (bus.ld_rsp_valid) m_busy[bus.ld_rsp_rd] = 1'b0;
            if (issue && bus.id_rd != 0) m_busy[bus.id_rd] = 1'b1;
            if (bus.ld_rsp_valid && m_cnt == 0) m_err = 1'b1;
            if (issue && !bus.ld_rsp_valid) m_cnt++;
            else if (bus.ld_rsp_valid && !issue && m_cnt > 0) m_cnt--;
            m_prev_flush = bus.flush;
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("fwd_sel",   64'(bus.fwd_sel),   64'(e.fwd));
            chk("stall_id",  64'(bus.stall_id),  64'(e.stall));
            chk("bubble_ex", 64'(bus.bubble_ex), 64'(e.bubble));
            chk("busy_vec",  64'(bus.busy_vec),  64'(e.busy));
            chk("sb_err",    64'(bus.sb_err),    64'(e.err));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.id_advance   = 1'b0;
        bus.id_rs        = '0;
        bus.id_rs_used   = '0;
        bus.id_rd        = '0;
        bus.id_is_load   = 1'b0;
        bus.ex_rs        = '0;
        bus.ex_rs_used   = '0;
        bus.mem_rd       = '0;
        bus.mem_wr_en    = 1'b0;
        bus.wb_rd        = '0;
        bus.wb_wr_en     = 1'b0;
        bus.ld_rsp_valid = 1'b0;
        bus.ld_rsp_rd    = '0;
        bus.flush        = 1'b0;
    endtask

    task automatic issue_load(input logic [AW-1:0] rd, input bit fl);
        bus.id_advance = 1'b1;
        bus.id_is_load = 1'b1;
        bus.id_rd      = rd;
        bus.flush      = fl;
        if (!fl) pending.push_back(rd);
    endtask

    task automatic rand_cycle();
        int idx;
        next_cycle();
        set_idle();
        for (int i = 0; i < NS; i++) begin
            bus.id_rs[i*AW +: AW] = AW'($urandom_range(0, 7));
            bus.ex_rs[i*AW +: AW] = AW'($urandom_range(0, 7));
        end
        bus.id_rs_used = NS'($urandom);
        bus.ex_rs_used = NS'($urandom);
        bus.mem_rd     = AW'($urandom_range(0, 7));
        bus.wb_rd      = AW'($urandom_range(0, 7));
        bus.mem_wr_en  = $urandom_range(0, 1) == 1;
        bus.wb_wr_en   = $urandom_range(0, 1) == 1;
        bus.flush      = $urandom_range(0, 15) == 0;
        bus.id_is_load = $urandom_range(0, 2) == 0;
        bus.id_rd      = AW'($urandom_range(0, 7));
        if (pending.size() > 0 && $urandom_range(0, 2) == 0) begin
            idx = $urandom_range(0, pending.size() - 1);
            bus.ld_rsp_valid = 1'b1;
            bus.ld_rsp_rd    = pending[idx];
            pending.delete(idx);
        end
        bus.id_advance = ($urandom_range(0, 3) != 0) && !ref_hazard();
        if (bus.id_advance && bus.id_is_load && !bus.flush) pending.push_back(bus.id_rd);
        expect_and_update();
    endtask

    task automatic respond(input logic [AW-1:0] rd);
        bus.ld_rsp_valid = 1'b1;
        bus.ld_rsp_rd    = rd;
        foreach (pending[k]) if (pending[k] == rd) begin pending.delete(k); break; end
    endtask

    initial begin
        set_idle();
        model_reset();
        // Reset cycles
        repeat (2) begin next_cycle(); set_idle(); expect_and_update(); end
        chk("reset_stall",  64'(bus.stall_id),  64'd0);
        chk("reset_bubble", 64'(bus.bubble_ex), 64'd0);
        chk("reset_busy",   64'(bus.busy_vec),  64'd0);
        chk("reset_err",    64'(bus.sb_err),    64'd0);
        next_cycle(); rst_n = 1'b1; set_idle(); expect_and_update();

        // Forwarding priority and qualifiers
        next_cycle(); set_idle();
        bus.ex_rs = {AW'(9), AW'(5)}; bus.ex_rs_used = 2'b01;
        bus.mem_rd = 5; bus.mem_wr_en = 1'b1;
        expect_and_update(); #1 chk("fwd_mem_basic", 64'(bus.fwd_sel), 64'h1);
        next_cycle(); set_idle();
        bus.ex_rs = {AW'(5), AW'(5)}; bus.ex_rs_used = 2'b01;
        bus.mem_rd = 5; bus.mem_wr_en = 1'b1; bus.wb_rd = 5; bus.wb_wr_en = 1'b1;
        expect_and_update(); #1 chk("fwd_mem_over_wb_unused1", 64'(bus.fwd_sel), 64'h1);
        next_cycle(); set_idle();
        bus.ex_rs = {AW'(6), AW'(0)}; bus.ex_rs_used = 2'b11;
        bus.mem_rd = 0; bus.mem_wr_en = 1'b1; bus.wb_rd = 6; bus.wb_wr_en = 1'b1;
        expect_and_update(); #1 chk("fwd_x0_and_wb", 64'(bus.fwd_sel), 64'h8);

        // Load-use stall and release one cycle after the response
        next_cycle(); set_idle(); issue_load(7, 1'b0); expect_and_update();
        for (int c = 1; c <= 4; c++) begin
            next_cycle(); set_idle();
            bus.id_rs = {AW'(7), AW'(3)}; bus.id_rs_used = 2'b10;
            if (c == 4) respond(7);
            expect_and_update(); #1 chk("load_use_stall", 64'(bus.stall_id), 64'd1);
        end
        next_cycle(); set_idle();
        bus.id_rs = {AW'(7), AW'(3)}; bus.id_rs_used = 2'b10;
        expect_and_update(); #1 chk("load_use_release", 64'(bus.stall_id), 64'd0);

        // Flush squashes a load and bubbles EX for two cycles
        next_cycle(); set_idle(); issue_load(8, 1'b1); expect_and_update();
        #1 chk("flush_bubble0", 64'(bus.bubble_ex), 64'd1);
        next_cycle(); set_idle(); expect_and_update();
        #1 chk("flush_bubble1", 64'(bus.bubble_ex), 64'd1);
        next_cycle(); set_idle(); expect_and_update();
        #1 chk("flush_done", 64'(bus.bubble_ex), 64'd0);
        chk("flush_no_busy", 64'(bus.busy_vec[8]), 64'd0);

        // Outstanding-load limit
        next_cycle(); set_idle(); issue_load(3, 1'b0); expect_and_update();
        next_cycle(); set_idle(); issue_load(4, 1'b0); expect_and_update();
        next_cycle(); set_idle(); bus.id_is_load = 1'b1; bus.id_rd = 5; expect_and_update();
        #1 chk("max_out_stall", 64'(bus.stall_id), 64'd1);
        next_cycle(); set_idle(); issue_load(5, 1'b0); respond(3); expect_and_update();
        next_cycle(); set_idle(); bus.id_is_load = 1'b1; bus.id_rd = 6; expect_and_update();
        #1 chk("max_out_still_full", 64'(bus.stall_id), 64'd1);
        next_cycle(); set_idle(); respond(4); expect_and_update();
        next_cycle(); set_idle(); respond(5); expect_and_update();

        // Randomised traffic
        repeat (400) rand_cycle();
        while (pending.size() > 0) begin
            next_cycle(); set_idle(); respond(pending[0]); expect_and_update();
        end

        // Spurious response: sticky error
        next_cycle(); set_idle(); bus.ld_rsp_valid = 1'b1; bus.ld_rsp_rd = 2; expect_and_update();
        repeat (3) begin next_cycle(); set_idle(); expect_and_update(); end
        chk("err_sticky", 64'(bus.sb_err), 64'd1);

        // Asynchronous reset in the middle of a stall
        next_cycle(); set_idle(); issue_load(9, 1'b0); expect_and_update();
        next_cycle(); set_idle();
        bus.id_rs = {AW'(0), AW'(9)}; bus.id_rs_used = 2'b01;
        expect_and_update();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("areset_stall",  64'(bus.stall_id),  64'd0);
        chk("areset_bubble", 64'(bus.bubble_ex), 64'd0);
        chk("areset_busy",   64'(bus.busy_vec),  64'd0);
        chk("areset_err",    64'(bus.sb_err),    64'd0);
        next_cycle(); expect_and_update();
        next_cycle(); rst_n = 1'b1; set_idle(); expect_and_update();
        repeat (20) rand_cycle();

        @(negedge clk); #1;
        if (q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL queue_drain: %0d left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
